// File: rtl/if_pc_redirect.sv
// IF-stage program counter with EX/ID redirect selection, stall-safe pending redirect and flush generation.
// Optional macro PC_REDIRECT_PERF_EN adds saturating counters of applied ID and EX redirects.
module if_pc_redirect #(
    parameter int                         INST_ADDR_WIDTH = 32,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0,
    parameter int                         PC_STEP         = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall_IF,
    input  logic                       early_jal_ID,
    input  logic [INST_ADDR_WIDTH-1:0] early_jal_PC_ID,
    input  logic                       branch_taken_EX,
    input  logic [INST_ADDR_WIDTH-1:0] branch_PC_EX,
    input  logic                       imem_ready,
    output logic                       imem_req,
    output logic [INST_ADDR_WIDTH-1:0] PC_IF,
    output logic                       flush_IF_ID,
    output logic                       flush_ID_EX,
    output logic                       misalign_IF,
    output logic [31:0]                redirect_cnt_ID,
    output logic [31:0]                redirect_cnt_EX
);

    localparam logic [INST_ADDR_WIDTH-1:0] STEP = INST_ADDR_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        PEND_IDLE = 2'b00,
        PEND_ID   = 2'b01,
        PEND_EX   = 2'b11
    } pend_e;

    pend_e                       r_state, w_state_nxt;
    logic [INST_ADDR_WIDTH-1:0]  r_pc, r_pend_pc, w_pend_pc_nxt;
    logic [INST_ADDR_WIDTH-1:0]  w_target, w_next_pc;
    logic                        r_req, w_adv, w_redirect, w_pend_vld, w_pend_ex;

    assign w_adv      = r_req & imem_ready & ~stall_IF;
    assign w_pend_vld = (r_state != PEND_IDLE);
    assign w_pend_ex  = (r_state == PEND_EX);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_target   = '0;
        w_redirect = 1'b0;
        if (branch_taken_EX) begin
            w_target   = branch_PC_EX;
            w_redirect = 1'b1;
        end else if (w_pend_vld) begin
            w_target   = r_pend_pc;
            w_redirect = 1'b1;
        end else if (early_jal_ID) begin
            w_target   = early_jal_PC_ID;
            w_redirect = 1'b1;
        end
        w_next_pc = w_redirect ? {w_target[INST_ADDR_WIDTH-1:2], 2'b00} : r_pc + STEP;
    end

    // A redirect seen while fetch cannot advance is parked; EX always overwrites, ID only fills an empty slot.
    always_comb begin
        w_state_nxt   = r_state;
        w_pend_pc_nxt = r_pend_pc;
        if (w_adv) begin
            w_state_nxt = PEND_IDLE;
        end else if (branch_taken_EX) begin
            w_state_nxt   = PEND_EX;
            w_pend_pc_nxt = branch_PC_EX;
        end else if (early_jal_ID && (r_state == PEND_IDLE)) begin
            w_state_nxt   = PEND_ID;
            w_pend_pc_nxt = early_jal_PC_ID;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= PEND_IDLE;
            r_pend_pc <= '0;
            r_pc      <= RESET_PC;
            r_req     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend_pc <= w_pend_pc_nxt;
            r_req     <= 1'b1;
            if (w_adv) begin
                r_pc <= w_next_pc;
            end
        end
    end

    assign imem_req    = r_req;
    assign PC_IF       = r_pc;
    assign flush_IF_ID = w_adv & (branch_taken_EX | w_pend_vld | early_jal_ID);
    assign flush_ID_EX = w_adv & (branch_taken_EX | w_pend_ex);
    assign misalign_IF = w_adv & w_redirect & (|w_target[1:0]);

`ifdef PC_REDIRECT_PERF_EN
    logic        w_sel_ex, w_sel_id;
    logic [31:0] r_cnt_id, r_cnt_ex;

    assign w_sel_ex = branch_taken_EX | w_pend_ex;
    assign w_sel_id = ~branch_taken_EX & (w_pend_vld ? ~w_pend_ex : early_jal_ID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_id <= '0;
            r_cnt_ex <= '0;
        end else begin
            if (w_adv && w_sel_id && !(&r_cnt_id)) begin
                r_cnt_id <= r_cnt_id + 32'd1;
            end
            if (w_adv && w_sel_ex && !(&r_cnt_ex)) begin
                r_cnt_ex <= r_cnt_ex + 32'd1;
            end
        end
    end

    assign redirect_cnt_ID = r_cnt_id;
    assign redirect_cnt_EX = r_cnt_ex;
`else
    assign redirect_cnt_ID = 32'h0;
    assign redirect_cnt_EX = 32'h0;
`endif

endmodule

// File: tb/tb_if_pc_redirect.sv
// Self-checking bench for if_pc_redirect: directed vector table, reset-mid-stall sequence and
// randomized traffic against a queue-based reference model.
module tb_if_pc_redirect;

    localparam int W = 32;
`ifdef PC_REDIRECT_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall_IF, early_jal_ID, branch_taken_EX, imem_ready;
    logic [W-1:0]  early_jal_PC_ID, branch_PC_EX, PC_IF;
    logic          imem_req, flush_IF_ID, flush_ID_EX, misalign_IF;
    logic [31:0]   redirect_cnt_ID, redirect_cnt_EX;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    if_pc_redirect #(
        .INST_ADDR_WIDTH(W),
        .RESET_PC       (32'h0),
        .PC_STEP        (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_IF       (stall_IF),
        .early_jal_ID   (early_jal_ID),
        .early_jal_PC_ID(early_jal_PC_ID),
        .branch_taken_EX(branch_taken_EX),
        .branch_PC_EX   (branch_PC_EX),
        .imem_ready     (imem_ready),
        .imem_req       (imem_req),
        .PC_IF          (PC_IF),
        .flush_IF_ID    (flush_IF_ID),
        .flush_ID_EX    (flush_ID_EX),
        .misalign_IF    (misalign_IF),
        .redirect_cnt_ID(redirect_cnt_ID),
        .redirect_cnt_EX(redirect_cnt_EX)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic jal, input logic [W-1:0] jpc,
                         input logic bte, input logic [W-1:0] bpc, input logic ready);
        stall_IF        = stall;
        early_jal_ID    = jal;
        early_jal_PC_ID = jpc;
        branch_taken_EX = bte;
        branch_PC_EX    = bpc;
        imem_ready      = ready;
    endtask

    typedef struct {
        logic         stall;
        logic         jal;
        logic [W-1:0] jpc;
        logic         bte;
        logic [W-1:0] bpc;
        logic         ready;
        logic [W-1:0] exp_pc;
        logic         exp_fi;
        logic         exp_fe;
        logic         exp_mis;
    } vec_t;

    typedef struct {
        logic [W-1:0] addr;
        logic         from_ex;
    } pend_t;

    vec_t  vecs[18];

    // Reference model state
    logic [W-1:0] m_pc;
    logic         m_req;
    pend_t        m_pend[$];
    logic [31:0]  m_cnt_id, m_cnt_ex;

    task automatic model_cycle(input logic stall, input logic jal, input logic [W-1:0] jpc,
                               input logic bte, input logic [W-1:0] bpc, input logic ready);
        logic         adv, redir, to_ex, to_id;
        logic [W-1:0] tgt;
        drive(stall, jal, jpc, bte, bpc, ready);
        #2;
        adv   = m_req && ready && !stall;
        redir = 1'b0;
        to_ex = 1'b0;
        to_id = 1'b0;
        tgt   = m_pc + 32'd4;
        if (bte) begin
            redir = 1'b1; to_ex = 1'b1; tgt = bpc;
        end else if (m_pend.size() != 0) begin
            redir = 1'b1; to_ex = m_pend[0].from_ex; to_id = !m_pend[0].from_ex; tgt = m_pend[0].addr;
        end else if (jal) begin
            redir = 1'b1; to_id = 1'b1; tgt = jpc;
        end
        check("rnd_pc",  PC_IF, m_pc);
        check("rnd_req", {31'b0, imem_req}, {31'b0, m_req});
        check("rnd_fi",  {31'b0, flush_IF_ID}, {31'b0, adv && (bte || m_pend.size() != 0 || jal)});
        check("rnd_fe",  {31'b0, flush_ID_EX}, {31'b0, adv && (bte || (m_pend.size() != 0 && m_pend[0].from_ex))});
        check("rnd_mis", {31'b0, misalign_IF}, {31'b0, adv && redir && (tgt % 4 != 0)});
        check("rnd_cid", redirect_cnt_ID, PERF ? m_cnt_id : 32'h0);
        check("rnd_cex", redirect_cnt_EX, PERF ? m_cnt_ex : 32'h0);
        if (adv) begin
            m_pc = redir ? tgt - (tgt % 4) : tgt;
            m_pend.delete();
            if (to_id && m_cnt_id != 32'hFFFF_FFFF) m_cnt_id++;
            if (to_ex && m_cnt_ex != 32'hFFFF_FFFF) m_cnt_ex++;
        end else if (bte) begin
            m_pend.delete();
            m_pend.push_back('{addr: bpc, from_ex: 1'b1});
        end else if (jal && m_pend.size() == 0) begin
            m_pend.push_back('{addr: jpc, from_ex: 1'b0});
        end
        m_req = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        //         stall jal jpc           bte bpc           rdy exp_pc        fi fe mis
        vecs[0]  = '{0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 0, 0, 0};
        vecs[1]  = '{0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0004, 0, 0, 0};
        vecs[2]  = '{0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0008, 0, 0, 0};
        vecs[3]  = '{0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_000C, 0, 0, 0};
        vecs[4]  = '{0, 1, 32'h40,       0, 32'h0,        1, 32'h0000_0010, 1, 0, 0};
        vecs[5]  = '{0, 1, 32'h40,       1, 32'h80,       1, 32'h0000_0040, 1, 1, 0};
        vecs[6]  = '{1, 0, 32'h0,        1, 32'h200,      1, 32'h0000_0080, 0, 0, 0};
        vecs[7]  = '{1, 1, 32'h300,      0, 32'h0,        1, 32'h0000_0080, 0, 0, 0};
        vecs[8]  = '{1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0080, 0, 0, 0};
        vecs[9]  = '{0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0080, 1, 1, 0};
        vecs[10] = '{0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0200, 0, 0, 0};
        vecs[11] = '{0, 1, 32'h43,       0, 32'h0,        1, 32'h0000_0204, 1, 0, 1};
        vecs[12] = '{0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0040, 0, 0, 0};
        vecs[13] = '{0, 1, 32'h100,      0, 32'h0,        0, 32'h0000_0044, 0, 0, 0};
        vecs[14] = '{0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0044, 1, 0, 0};
        vecs[15] = '{0, 0, 32'h0,        1, 32'hFFFF_FFFC, 1, 32'h0000_0100, 1, 1, 0};
        vecs[16] = '{0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFF_FFFC, 0, 0, 0};
        vecs[17] = '{0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 0, 0, 0};

        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        #12;
        check("rst_pc",  PC_IF, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_fi",  {31'b0, flush_IF_ID}, 32'h0);
        check("rst_fe",  {31'b0, flush_ID_EX}, 32'h0);
        check("rst_mis", {31'b0, misalign_IF}, 32'h0);
        check("rst_cid", redirect_cnt_ID, 32'h0);
        check("rst_cex", redirect_cnt_EX, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        check("rel_req0", {31'b0, imem_req}, 32'h0);
        check("rel_pc0",  PC_IF, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].stall, vecs[i].jal, vecs[i].jpc, vecs[i].bte, vecs[i].bpc, vecs[i].ready);
            #2;
            check($sformatf("vec%0d_pc", i),  PC_IF, vecs[i].exp_pc);
            check($sformatf("vec%0d_req", i), {31'b0, imem_req}, 32'h1);
            check($sformatf("vec%0d_fi", i),  {31'b0, flush_IF_ID}, {31'b0, vecs[i].exp_fi});
            check($sformatf("vec%0d_fe", i),  {31'b0, flush_ID_EX}, {31'b0, vecs[i].exp_fe});
            check($sformatf("vec%0d_mis", i), {31'b0, misalign_IF}, {31'b0, vecs[i].exp_mis});
            @(posedge clk);
            #1;
        end
        check("vec_cnt_id", redirect_cnt_ID, PERF ? 32'd3 : 32'd0);
        check("vec_cnt_ex", redirect_cnt_EX, PERF ? 32'd3 : 32'd0);

        // Reset while stalled with an EX redirect parked: the redirect must vanish.
        drive(1, 0, 32'h0, 1, 32'h500, 1);
        @(posedge clk);
        #1;
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("mid_rst_pc",  PC_IF, 32'h0);
        check("mid_rst_req", {31'b0, imem_req}, 32'h0);
        check("mid_rst_cid", redirect_cnt_ID, 32'h0);
        check("mid_rst_cex", redirect_cnt_EX, 32'h0);
        @(posedge clk);
        #1;
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        #2;
        check("post_rst_pc", PC_IF, 32'h0);
        check("post_rst_fi", {31'b0, flush_IF_ID}, 32'h0);
        check("post_rst_fe", {31'b0, flush_ID_EX}, 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_seq", PC_IF, 32'h4);

        m_pc     = 32'h4;
        m_req    = 1'b1;
        m_pend.delete();
        m_cnt_id = 32'h0;
        m_cnt_ex = 32'h0;
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] jpc, bpc;
            jpc = $urandom;
            bpc = $urandom;
            if ($urandom_range(0, 3) != 0) jpc[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) bpc[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) bpc = 32'hFFFF_FFF8;
            model_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, jpc,
                        $urandom_range(0, 5) == 0, bpc, $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
